l2_flush_walker: RTL and testbench
==================================

Name: l2_flush_walker

Overview:
- Initiator-side controller for the L2 per-set register arrays (dirty array, tag array).
- On request, it walks every set index in order and reads each set's dirty bit and tag through the arrays' registered read port.
- For each dirty set, it issues a write-back request to the memory side, then clears the dirty bit through the arrays' write port.
- Used for cache flush before DMA handoff and at end of test.

Parameters:
- s_index, 3, index width; num_sets = 2**s_index
- s_tag, 23, tag width returned by the tag array

Ports:
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  flush request, sampled in IDLE only
- busy  out  1  high while a walk is in progress
- done  out  1  one-cycle pulse when the walk completes
- arr_rindex  out  s_index  read index to the dirty/tag arrays
- arr_dirty  in  1  dirty array dataout; registered, valid the cycle after arr_rindex
- arr_tag  in  s_tag  tag array dataout; same timing as arr_dirty
- arr_load  out  1  dirty array write enable
- arr_windex  out  s_index  dirty array write index
- arr_datain  out  1  dirty array write data; constant 0
- wb_req  out  1  write-back request to memory side
- wb_tag  out  s_tag  tag of the set being written back
- wb_index  out  s_index  index of the set being written back
- wb_ack  in  1  write-back accepted/complete

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, idx=0, captured tag=0.
  - busy, done, arr_load, wb_req = 0; arr_rindex, arr_windex, wb_tag, wb_index = 0.
  - Reset mid-walk abandons the walk immediately; no further array writes and no dirty bits cleared.
- States: IDLE, READ, CHECK, WB, CLEAR, DONE. done is a Moore output of DONE. busy=1 in READ, CHECK, WB, CLEAR.
- IDLE:
  - start=1 -> READ with idx=0.
  - start while not IDLE is ignored; no queueing.
- READ:
  - Drive arr_rindex=idx, then go to CHECK.
  - arr_rindex holds idx in every state except IDLE, where it is 0.
- CHECK:
  - Sample arr_dirty and arr_tag; capture the tag into a register.
  - dirty=1 -> WB.
  - dirty=0, idx != num_sets-1 -> idx+1, READ.
  - dirty=0, idx == num_sets-1 -> DONE.
- WB:
  - wb_req=1; wb_tag = captured tag; wb_index = idx. All three are held stable until the ack.
  - wb_ack=1 (including the first WB cycle) -> CLEAR.
  - wb_ack outside WB is ignored.
- CLEAR (exactly one cycle):
  - arr_load=1, arr_windex=idx, arr_datain=0.
  - Then: idx != num_sets-1 -> idx+1, READ; otherwise -> DONE.
  - The array bypass is never exercised: the next read is issued one cycle after the write.
- DONE: done=1 for one cycle, then IDLE. idx returns to 0.
- idx is s_index bits wide and never wraps: termination uses the compare against num_sets-1, not overflow.
- Latency:
  - start sampled at edge E0 -> first READ cycle after E0.
  - Clean set costs 2 cycles.
  - Dirty set costs 3 + (cycles until ack, counted from the first WB cycle).
  - All-clean walk: done high in cycle 2*num_sets+1 after E0.
- Dirty bits set by other logic during a walk are handled by index order only: an already-visited index is not revisited.

Test Plan:
- Reset/idle: hold rst_n=0 for 3 cycles, then release with start=0 -> all outputs 0 and they stay 0 for 20 cycles.
- All clean, s_index=3: pulse start -> busy for 16 cycles, done=1 in cycle 17 after start, arr_load never 1, wb_req never 1, arr_rindex steps 0..7.
- Dirty at index 2 (tag 0x1A2B), wb_ack asserted 3 cycles after wb_req rises:
  - wb_req high for exactly 4 cycles with wb_tag=0x1A2B and wb_index=2.
  - Next cycle: arr_load=1, arr_windex=2, arr_datain=0.
  - Walk continues at index 3; total walk length is 16+6 cycles.
- Dirty at index 7 (last) with wb_ack in the same cycle wb_req rises -> CLEAR on index 7, then done next cycle; idx wraps to 0 only via IDLE.
- Dirty at indices 0,1,...,7, ack immediate -> 8 write-backs in index order, 8 clears, done at cycle 8*3+8*1+1 = 33 after start.
- Reset mid-WB: rst_n=0 while wb_req=1 at index 4 -> wb_req and busy drop asynchronously, index 4 is not cleared; a start after release restarts at index 0; a start pulse during busy produces no second walk.

Source files
------------

// File: rtl/l2_flush_walker.sv
// ----------------------------------------------------------------------------
// l2_flush_walker : walks every L2 set, writes back dirty sets, clears dirty.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module l2_flush_walker #(
   parameter int S_INDEX = 3,
   parameter int S_TAG   = 23
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_start,
   output logic               o_busy,
   output logic               o_done,
   output logic [S_INDEX-1:0] o_arr_rindex,
   input  logic               i_arr_dirty,
   input  logic [S_TAG-1:0]   i_arr_tag,
   output logic               o_arr_load,
   output logic [S_INDEX-1:0] o_arr_windex,
   output logic               o_arr_datain,
   output logic               o_wb_req,
   output logic [S_TAG-1:0]   o_wb_tag,
   output logic [S_INDEX-1:0] o_wb_index,
   input  logic               i_wb_ack
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_READ  = 3'd1,
      S_CHECK = 3'd2,
      S_WB    = 3'd3,
      S_CLEAR = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   localparam logic [S_INDEX-1:0] c_last_idx = {S_INDEX{1'b1}};
   localparam logic [S_INDEX-1:0] c_one      = S_INDEX'(1);

   state_t               r_state;
   logic [S_INDEX-1:0]   r_idx;
   logic [S_TAG-1:0]     r_tag;
   logic                 r_busy;
   logic                 r_done;
   logic                 r_load;
   logic                 r_wb_req;
   logic                 w_last;

   assign w_last = (r_idx == c_last_idx);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_idx    <= '0;
         r_tag    <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_load   <= 1'b0;
         r_wb_req <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_load <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_state <= S_READ;
                  r_idx   <= '0;
                  r_busy  <= 1'b1;
               end
            end
            S_READ: begin
               r_state <= S_CHECK;
            end
            S_CHECK: begin
               if (i_arr_dirty) begin
                  r_tag    <= i_arr_tag;
                  r_wb_req <= 1'b1;
                  r_state  <= S_WB;
               end else if (w_last) begin
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  r_idx   <= r_idx + c_one;
                  r_state <= S_READ;
               end
            end
            S_WB: begin
               if (i_wb_ack) begin
                  r_wb_req <= 1'b0;
                  r_load   <= 1'b1;
                  r_state  <= S_CLEAR;
               end
            end
            S_CLEAR: begin
               // Termination is by compare, so idx never overflows mid-walk
               if (w_last) begin
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  r_idx   <= r_idx + c_one;
                  r_state <= S_READ;
               end
            end
            S_DONE: begin
               r_idx   <= '0;
               r_state <= S_IDLE;
            end
            default: begin
               r_idx    <= '0;
               r_busy   <= 1'b0;
               r_wb_req <= 1'b0;
               r_state  <= S_IDLE;
            end
         endcase
      end
   end

   // idx is 0 whenever idle, so all index ports can follow it directly
   assign o_busy       = r_busy;
   assign o_done       = r_done;
   assign o_arr_rindex = r_idx;
   assign o_arr_load   = r_load;
   assign o_arr_windex = r_idx;
   assign o_arr_datain = 1'b0;
   assign o_wb_req     = r_wb_req;
   assign o_wb_tag     = r_tag;
   assign o_wb_index   = r_idx;

endmodule

`default_nettype wire

// File: tb/tb_l2_flush_walker.sv
// ----------------------------------------------------------------------------
// tb_l2_flush_walker : randomized bench for l2_flush_walker with trace model.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_l2_flush_walker;

   localparam int S_INDEX  = 3;
   localparam int S_TAG    = 23;
   localparam int NUM_SETS = 8;

   logic               clk;
   logic               rst_n;
   logic               i_start;
   logic               o_busy;
   logic               o_done;
   logic [S_INDEX-1:0] o_arr_rindex;
   logic               arr_dirty_q;
   logic [S_TAG-1:0]   arr_tag_q;
   logic               o_arr_load;
   logic [S_INDEX-1:0] o_arr_windex;
   logic               o_arr_datain;
   logic               o_wb_req;
   logic [S_TAG-1:0]   o_wb_tag;
   logic [S_INDEX-1:0] o_wb_index;
   logic               i_wb_ack;

   l2_flush_walker #(.S_INDEX(S_INDEX), .S_TAG(S_TAG)) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_start      (i_start),
      .o_busy       (o_busy),
      .o_done       (o_done),
      .o_arr_rindex (o_arr_rindex),
      .i_arr_dirty  (arr_dirty_q),
      .i_arr_tag    (arr_tag_q),
      .o_arr_load   (o_arr_load),
      .o_arr_windex (o_arr_windex),
      .o_arr_datain (o_arr_datain),
      .o_wb_req     (o_wb_req),
      .o_wb_tag     (o_wb_tag),
      .o_wb_index   (o_wb_index),
      .i_wb_ack     (i_wb_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural dirty/tag arrays with a registered read port
   logic [NUM_SETS-1:0] mem_dirty;
   logic [NUM_SETS-1:0] g_dirty;
   logic [S_TAG-1:0]    g_tag [NUM_SETS];
   int                  g_dly [NUM_SETS];
   logic                tb_init;

   always @(posedge clk) begin
      if (tb_init) mem_dirty <= g_dirty;
      else if (o_arr_load) mem_dirty[o_arr_windex] <= o_arr_datain;
      arr_dirty_q <= mem_dirty[o_arr_rindex];
      arr_tag_q   <= g_tag[o_arr_rindex];
   end

   typedef struct packed {
      logic               busy;
      logic               done;
      logic               load;
      logic               wbreq;
      logic               ack;
      logic [S_INDEX-1:0] rindex;
      logic [S_INDEX-1:0] windex;
      logic [S_INDEX-1:0] wbindex;
      logic [S_TAG-1:0]   wbtag;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks;
   int   n_errors;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Expected per-cycle outputs of one walk, from the set-level cost rules
   task automatic build_trace();
      exp_t e;
      exp_q.delete();
      for (int i = 0; i < NUM_SETS; i++) begin
         for (int p = 0; p < 2; p++) begin
            e = '0; e.busy = 1'b1; e.rindex = i[2:0]; e.ack = 1'($urandom);
            exp_q.push_back(e);
         end
         if (g_dirty[i]) begin
            for (int j = 0; j <= g_dly[i]; j++) begin
               e = '0; e.busy = 1'b1; e.rindex = i[2:0]; e.wbreq = 1'b1;
               e.wbtag = g_tag[i]; e.wbindex = i[2:0]; e.ack = (j == g_dly[i]);
               exp_q.push_back(e);
            end
            e = '0; e.busy = 1'b1; e.rindex = i[2:0]; e.load = 1'b1;
            e.windex = i[2:0]; e.ack = 1'($urandom);
            exp_q.push_back(e);
         end
      end
      e = '0; e.done = 1'b1; e.rindex = 3'(NUM_SETS - 1); e.ack = 1'($urandom);
      exp_q.push_back(e);
   endtask

   task automatic load_arrays();
      @(negedge clk);
      tb_init = 1'b1;
      @(negedge clk);
      tb_init = 1'b0;
   endtask

   // Pulse start, then compare every cycle; stop_at >= 0 ends early at that cycle
   task automatic run_trace(input int stop_at);
      exp_t e;
      @(negedge clk);
      i_start  = 1'b1;
      i_wb_ack = 1'b0;
      @(posedge clk);
      for (int k = 0; k < exp_q.size(); k++) begin
         @(negedge clk);
         e = exp_q[k];
         check_val("busy",   32'(o_busy),       32'(e.busy));
         check_val("done",   32'(o_done),       32'(e.done));
         check_val("rindex", 32'(o_arr_rindex), 32'(e.rindex));
         check_val("load",   32'(o_arr_load),   32'(e.load));
         check_val("wb_req", 32'(o_wb_req),     32'(e.wbreq));
         if (e.load) begin
            check_val("windex", 32'(o_arr_windex), 32'(e.windex));
            check_val("datain", 32'(o_arr_datain), 32'd0);
         end
         if (e.wbreq) begin
            check_val("wb_tag",   32'(o_wb_tag),   32'(e.wbtag));
            check_val("wb_index", 32'(o_wb_index), 32'(e.wbindex));
         end
         if (k == stop_at) begin
            i_start  = 1'b0;
            i_wb_ack = 1'b0;
            return;
         end
         i_start  = 1'($urandom);
         i_wb_ack = e.ack;
      end
      @(negedge clk);
      i_start  = 1'b0;
      i_wb_ack = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check_val("idle_busy",   32'(o_busy),   32'd0);
         check_val("idle_wb_req", 32'(o_wb_req), 32'd0);
         check_val("idle_done",   32'(o_done),   32'd0);
      end
      check_val("dirty_cleared", 32'(mem_dirty), 32'd0);
   endtask

   task automatic set_walk(input logic [NUM_SETS-1:0] dirty, input int max_dly);
      g_dirty = dirty;
      for (int i = 0; i < NUM_SETS; i++) begin
         g_tag[i] = 23'($urandom);
         g_dly[i] = (max_dly < 0) ? 0 : $urandom_range(0, max_dly);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int stop_at;
      n_checks = 0;
      n_errors = 0;
      rst_n    = 1'b0;
      i_start  = 1'b0;
      i_wb_ack = 1'b0;
      tb_init  = 1'b0;
      set_walk('0, -1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Reset / idle
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         check_val("rst_busy",     32'(o_busy),       32'd0);
         check_val("rst_done",     32'(o_done),       32'd0);
         check_val("rst_load",     32'(o_arr_load),   32'd0);
         check_val("rst_wb_req",   32'(o_wb_req),     32'd0);
         check_val("rst_rindex",   32'(o_arr_rindex), 32'd0);
         check_val("rst_windex",   32'(o_arr_windex), 32'd0);
         check_val("rst_wb_tag",   32'(o_wb_tag),     32'd0);
         check_val("rst_wb_index", 32'(o_wb_index),   32'd0);
         check_val("rst_datain",   32'(o_arr_datain), 32'd0);
      end

      // All clean
      set_walk(8'h00, -1);
      load_arrays();
      build_trace();
      run_trace(-1);

      // Dirty at index 2, ack three cycles after wb_req rises
      set_walk(8'h04, -1);
      g_tag[2] = 23'h1A2B;
      g_dly[2] = 3;
      load_arrays();
      build_trace();
      run_trace(-1);

      // Dirty at last index, immediate ack
      set_walk(8'h80, -1);
      load_arrays();
      build_trace();
      run_trace(-1);

      // Every set dirty, immediate ack
      set_walk(8'hFF, -1);
      load_arrays();
      build_trace();
      check_val("all_dirty_len", 32'(exp_q.size()), 32'd33);
      run_trace(-1);

      // Randomized walks
      for (int r = 0; r < 8; r++) begin
         set_walk(8'($urandom), 4);
         load_arrays();
         build_trace();
         run_trace(-1);
      end

      // Reset in the middle of the index-4 write-back
      set_walk(8'h50, -1);
      g_dly[4] = 20;
      load_arrays();
      build_trace();
      stop_at = -1;
      for (int k = 0; k < exp_q.size(); k++)
         if (stop_at < 0 && exp_q[k].wbreq && exp_q[k].wbindex == 3'd4) stop_at = k + 1;
      run_trace(stop_at);
      #2;
      rst_n = 1'b0;
      #1;
      check_val("mid_rst_busy",   32'(o_busy),       32'd0);
      check_val("mid_rst_wb_req", 32'(o_wb_req),     32'd0);
      check_val("mid_rst_load",   32'(o_arr_load),   32'd0);
      check_val("mid_rst_rindex", 32'(o_arr_rindex), 32'd0);
      repeat (2) @(negedge clk);
      check_val("mid_rst_idx4_dirty", 32'(mem_dirty[4]), 32'd1);
      rst_n = 1'b1;
      for (int i = 0; i < NUM_SETS; i++) g_dly[i] = $urandom_range(0, 2);
      build_trace();
      run_trace(-1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
